// File: rtl/pcma_pkg.sv
// Shared PCMA detector definitions: default datapath sizes, scan FSM encoding
// and the minimum window length that keeps window ends out of the scan.
package pcma_pkg;

  localparam int DATA_WIDTH_DEF      = 16;
  localparam int BOUND_NUM_DEF       = 32;
  localparam int BOUND_NUM_WIDTH_DEF = 5;

  // A window must outlast SCAN (BOUND_NUM edges) plus OUT (one edge).
  function automatic int min_win_for(input int bound_num);
    return bound_num + 2;
  endfunction

  localparam int MIN_WIN = min_win_for(BOUND_NUM_DEF);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_OUT  = 2'd2
  } scan_state_e;

endpackage

// File: rtl/bin_argmax_scan.sv
// Sequential argmax over a snapshot of histogram bins, one bin per clock.
// Ties keep the lowest index; done_o is high for the single OUT cycle.
module bin_argmax_scan
  import pcma_pkg::*;
#(
  parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int BOUND_NUM       = BOUND_NUM_DEF,
  parameter int BOUND_NUM_WIDTH = BOUND_NUM_WIDTH_DEF
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            clear_i,
  input  logic                            start_i,
  input  logic [DATA_WIDTH*BOUND_NUM-1:0] snap_i,
  output logic [BOUND_NUM_WIDTH-1:0]      best_idx_o,
  output logic                            done_o
);

  localparam logic [BOUND_NUM_WIDTH-1:0] LAST_IDX = BOUND_NUM_WIDTH'(BOUND_NUM - 1);
  localparam logic [BOUND_NUM_WIDTH-1:0] IDX_ONE  = BOUND_NUM_WIDTH'(1);

  scan_state_e                state_r;
  logic [BOUND_NUM_WIDTH-1:0] j_r;
  logic [DATA_WIDTH-1:0]      best_val_r;
  logic [DATA_WIDTH-1:0]      cur_s;

  assign cur_s = snap_i[j_r*DATA_WIDTH +: DATA_WIDTH];

  // Scan sequencer: IDLE -> SCAN (BOUND_NUM edges) -> OUT (one edge) -> IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      j_r        <= {BOUND_NUM_WIDTH{1'b0}};
      best_val_r <= {DATA_WIDTH{1'b0}};
      best_idx_o <= {BOUND_NUM_WIDTH{1'b0}};
      done_o     <= 1'b0;
    end else if (clear_i) begin
      state_r <= ST_IDLE;
      j_r     <= {BOUND_NUM_WIDTH{1'b0}};
      done_o  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            state_r    <= ST_SCAN;
            j_r        <= {BOUND_NUM_WIDTH{1'b0}};
            best_val_r <= {DATA_WIDTH{1'b0}};
            best_idx_o <= {BOUND_NUM_WIDTH{1'b0}};
          end
        end
        ST_SCAN: begin
          if (cur_s > best_val_r) begin
            best_val_r <= cur_s;
            best_idx_o <= j_r;
          end
          if (j_r == LAST_IDX) begin
            state_r <= ST_OUT;
            done_o  <= 1'b1;
          end else begin
            j_r <= j_r + IDX_ONE;
          end
        end
        ST_OUT: begin
          state_r <= ST_IDLE;
          done_o  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          done_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/bound_hist_acc.sv
// Windowed boundary-bin histogram feeding the lock calculator: accumulates
// samples, snapshots at window end and publishes bins plus peak index.
module bound_hist_acc
  import pcma_pkg::*;
#(
  parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int BOUND_NUM       = BOUND_NUM_DEF,
  parameter int BOUND_NUM_WIDTH = BOUND_NUM_WIDTH_DEF,
  parameter int WIN_WIDTH       = 16
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            bin_val_i,
  input  logic [BOUND_NUM_WIDTH-1:0]      bin_idx_i,
  input  logic [WIN_WIDTH-1:0]            win_len_i,
  input  logic                            clear_i,
  output logic                            val_o,
  output logic [BOUND_NUM_WIDTH-1:0]      max_num_o,
  output logic [DATA_WIDTH*BOUND_NUM-1:0] data_o,
  output logic                            sat_o
);

  localparam logic [WIN_WIDTH-1:0]  MIN_WIN_W = WIN_WIDTH'(min_win_for(BOUND_NUM));
  localparam logic [WIN_WIDTH-1:0]  CNT_ONE   = WIN_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] BIN_ONE   = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] BIN_MAX   = {DATA_WIDTH{1'b1}};

  logic [DATA_WIDTH-1:0]            bins_r [BOUND_NUM];
  logic [DATA_WIDTH*BOUND_NUM-1:0]  snap_r;
  logic [DATA_WIDTH*BOUND_NUM-1:0]  snap_next_s;
  logic [WIN_WIDTH-1:0]             count_r;
  logic [WIN_WIDTH-1:0]             win_r;
  logic [WIN_WIDTH-1:0]             win_clamp_s;
  logic [WIN_WIDTH-1:0]             win_eff_s;
  logic                             bin_full_s;
  logic                             win_end_s;
  logic                             scan_done_s;
  logic [BOUND_NUM_WIDTH-1:0]       best_idx_s;

  // Window length clamp, window-end detect and the bins-plus-this-sample image.
  always_comb begin
    win_clamp_s = (win_len_i < MIN_WIN_W) ? MIN_WIN_W : win_len_i;
    win_eff_s   = (count_r == {WIN_WIDTH{1'b0}}) ? win_clamp_s : win_r;
    bin_full_s  = (bins_r[bin_idx_i] == BIN_MAX);
    win_end_s   = bin_val_i && !clear_i && ((count_r + CNT_ONE) == win_eff_s);
    snap_next_s = {(DATA_WIDTH*BOUND_NUM){1'b0}};
    for (int i = 0; i < BOUND_NUM; i++) begin
      if (bin_val_i && (bin_idx_i == BOUND_NUM_WIDTH'(i)) && !bin_full_s) begin
        snap_next_s[i*DATA_WIDTH +: DATA_WIDTH] = bins_r[i] + BIN_ONE;
      end else begin
        snap_next_s[i*DATA_WIDTH +: DATA_WIDTH] = bins_r[i];
      end
    end
  end

  // Live histogram, sample counter, latched window length and sticky saturation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < BOUND_NUM; i++) bins_r[i] <= {DATA_WIDTH{1'b0}};
      snap_r  <= {(DATA_WIDTH*BOUND_NUM){1'b0}};
      count_r <= {WIN_WIDTH{1'b0}};
      win_r   <= MIN_WIN_W;
      sat_o   <= 1'b0;
    end else if (clear_i) begin
      for (int i = 0; i < BOUND_NUM; i++) bins_r[i] <= {DATA_WIDTH{1'b0}};
      count_r <= {WIN_WIDTH{1'b0}};
      sat_o   <= 1'b0;
    end else begin
      if (count_r == {WIN_WIDTH{1'b0}}) win_r <= win_clamp_s;
      if (bin_val_i) begin
        if (win_end_s) begin
          snap_r  <= snap_next_s;
          for (int i = 0; i < BOUND_NUM; i++) bins_r[i] <= {DATA_WIDTH{1'b0}};
          count_r <= {WIN_WIDTH{1'b0}};
        end else begin
          bins_r[bin_idx_i] <= snap_next_s[bin_idx_i*DATA_WIDTH +: DATA_WIDTH];
          count_r           <= count_r + CNT_ONE;
        end
        if (bin_full_s) sat_o <= 1'b1;
      end
    end
  end

  bin_argmax_scan #(
    .DATA_WIDTH     (DATA_WIDTH),
    .BOUND_NUM      (BOUND_NUM),
    .BOUND_NUM_WIDTH(BOUND_NUM_WIDTH)
  ) u_scan (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear_i   (clear_i),
    .start_i   (win_end_s),
    .snap_i    (snap_r),
    .best_idx_o(best_idx_s),
    .done_o    (scan_done_s)
  );

  // Publish snapshot and peak once per completed scan; outputs hold otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      val_o     <= 1'b0;
      data_o    <= {(DATA_WIDTH*BOUND_NUM){1'b0}};
      max_num_o <= {BOUND_NUM_WIDTH{1'b0}};
    end else if (clear_i) begin
      val_o <= 1'b0;
    end else begin
      val_o <= scan_done_s;
      if (scan_done_s) begin
        data_o    <= snap_r;
        max_num_o <= best_idx_s;
      end
    end
  end

endmodule

// File: doc/bound_hist_acc.md
Name: bound_hist_acc

Overview:
- Upstream feeder of the lock calculator in the PCMA detector datapath.
- Accumulates per-symbol boundary-bin indices into a BOUND_NUM-bin histogram over a programmable window.
- At window end, snapshots the histogram, finds the peak bin with a sequential scan, and presents the flattened bins and peak index to the lock calculator (data/max_num/val pulse).

Parameters:
- DATA_WIDTH, 16, width of each bin counter and each word of data_o
- BOUND_NUM, 32, number of bins; power of two
- BOUND_NUM_WIDTH, 5, log2(BOUND_NUM)
- WIN_WIDTH, 16, width of the window-length input and sample counter

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- bin_val_i  in  1  sample strobe; one sample per cycle when high
- bin_idx_i  in  BOUND_NUM_WIDTH  bin index of the sample
- win_len_i  in  WIN_WIDTH  samples per window; sampled when the window sample counter is 0
- clear_i  in  1  synchronous flush
- val_o  out  1  one-cycle pulse; data_o/max_num_o valid
- max_num_o  out  BOUND_NUM_WIDTH  index of the largest bin
- data_o  out  DATA_WIDTH*BOUND_NUM  bin i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- sat_o  out  1  sticky: some bin saturated

Behaviour:
- Reset (async, reset_n low): all bins, snapshot, counters, data_o, max_num_o, val_o and sat_o go to 0. FSM goes to IDLE. Release is synchronous to clk.
- Effective window length L = max(win_len_i, BOUND_NUM+2). L is latched when the sample counter is 0 and held for the whole window.
- Accept: at an edge with bin_val_i=1:
  - bin[bin_idx_i] += 1, saturating at 2^DATA_WIDTH-1.
  - A saturating increment sets sat_o.
  - The sample counter increments.
- Window end: the accepted sample is the L-th at edge k. At that same edge:
  - snapshot <= bins including this sample's increment.
  - All live bins <= 0 and the counter <= 0.
  - FSM enters SCAN. The next window starts at edge k+1.
- FSM states:
  - IDLE: leave on window end.
  - SCAN: scan index j = 0..BOUND_NUM-1, one bin per edge (k+1..k+BOUND_NUM). best is replaced only if snapshot[j] > best (strict), so ties keep the lowest index. After j = BOUND_NUM-1, go to OUT.
  - OUT: one cycle. At edge k+BOUND_NUM+1: val_o=1, data_o <= snapshot, max_num_o <= best index. Then return to IDLE.
- Latency: val_o is high in the cycle after edge k+BOUND_NUM+1 (33 edges after the last sample for the defaults).
- Outputs hold between pulses. val_o is low except for the single OUT cycle.
- Because L >= BOUND_NUM+2, a new window end can never occur during SCAN/OUT. The clamp guarantees this; no overlap logic is needed.
- clear_i has highest priority after reset:
  - Bins, counter and sat_o go to 0 and the FSM goes to IDLE.
  - A sample in the same cycle is discarded.
  - An in-progress scan is aborted with no val_o.
  - data_o and max_num_o keep their last values.
- bin_val_i=0 cycles do not advance the counter. Gaps of any length are allowed.
- All-zero snapshot is not possible, since each window has L>0 samples.

Decomposition:
- Shared package pcma_pkg holds:
  - BOUND_NUM, BOUND_NUM_WIDTH and DATA_WIDTH defaults, shared with lock_calc.
  - The FSM state encoding (IDLE, SCAN, OUT).
  - The clamp constant MIN_WIN = BOUND_NUM+2.
- One sub-module, bin_argmax_scan, holds the SCAN/OUT sequencer.
  - Inputs: start pulse, snapshot bus.
  - Outputs: best index, done pulse.
- Histogram accumulation and windowing stay in bound_hist_acc.

Test Plan:
- Reset mid-scan: assert reset_n=0 during SCAN -> val_o, sat_o, data_o and max_num_o are 0 immediately (async), with no later val_o.
- Basic window: win_len_i=40, samples idx = i%8 for i=0..39 -> one val_o 33 cycles after the 40th sample; bins 0..7 = 5, others 0; max_num_o=0 (tie, lowest index).
- Peak detection: win_len_i=64, 34 samples of idx 17 and 30 of idx 3 (interleaved, with gaps) -> data_o bin17=34, bin3=30; max_num_o=17.
- Clamp and back-to-back: win_len_i=5 -> windows of 34 samples. Continuous stream of 68 samples idx 31 -> two val_o pulses, each with bin31=34 and max_num_o=31. Samples after the first window end are counted in the second window.
- Saturation: DATA_WIDTH=4, win_len_i=40, all idx 2 -> bin2=15, sat_o=1 held after val_o until clear_i; max_num_o=2.
- Clear abort: clear_i during SCAN together with a sample -> no val_o; the next window counts from 0 and excludes that sample.
